// File: rtl/branch_cmp_pkg.sv
// Shared definitions for the branch-condition unit: op encoding and result flags.
package branch_cmp_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_EQ  = 4'd0,
    OP_NE  = 4'd1,
    OP_LT  = 4'd2,
    OP_GE  = 4'd3,
    OP_LTU = 4'd4,
    OP_GEU = 4'd5,
    OP_LEZ = 4'd6,
    OP_GTZ = 4'd7,
    OP_LTZ = 4'd8,
    OP_GEZ = 4'd9
  } op_e;

  // Result flags stored per FIFO entry alongside the tag.
  typedef struct packed {
    logic taken;
    logic op_err;
  } flags_t;

endpackage

// File: rtl/branch_cmp_if.sv
// Request/result handshake bundle between the decode stage and the branch unit.
interface branch_cmp_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 5
);
  import branch_cmp_pkg::*;

  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [OP_W-1:0]            in_op;
  logic [WIDTH-1:0]           in_a;
  logic [WIDTH-1:0]           in_b;
  logic [TAG_W-1:0]           in_tag;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_taken;
  logic                       out_op_err;
  logic [TAG_W-1:0]           out_tag;
  logic [$clog2(DEPTH+1)-1:0] count;

  modport slave (
    input  flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_taken, out_op_err, out_tag, count
  );

  modport master (
    output flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_taken, out_op_err, out_tag, count
  );

endinterface

// File: rtl/branch_cmp_cmp_eval.sv
// Combinational evaluation of one branch comparison mode on two operands.
module cmp_eval
  import branch_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             taken,
  output logic             op_err
);

  logic a_neg;
  logic a_zero;

  assign a_neg  = a[WIDTH-1];
  assign a_zero = (a == '0);

  // Select the comparison; unknown encodings report an error and never take.
  always_comb begin
    taken  = 1'b0;
    op_err = 1'b0;
    case (op)
      OP_EQ:   taken = (a == b);
      OP_NE:   taken = (a != b);
      OP_LT:   taken = ($signed(a) <  $signed(b));
      OP_GE:   taken = ($signed(a) >= $signed(b));
      OP_LTU:  taken = (a <  b);
      OP_GEU:  taken = (a >= b);
      OP_LEZ:  taken = a_neg || a_zero;
      OP_GTZ:  taken = !a_neg && !a_zero;
      OP_LTZ:  taken = a_neg;
      OP_GEZ:  taken = !a_neg;
      default: op_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_cmp.sv
// Branch-condition unit: evaluates a request and queues the tagged result in a small FIFO.
module branch_cmp
  import branch_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  branch_cmp_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    flags_t           flags;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  flags_t             new_flags;
  entry_t             head;
  logic               in_ready;
  logic               out_valid;
  logic               push;
  logic               pop;

  cmp_eval #(.WIDTH(WIDTH)) u_eval (
    .op     (bus.in_op),
    .a      (bus.in_a),
    .b      (bus.in_b),
    .taken  (new_flags.taken),
    .op_err (new_flags.op_err)
  );

  // reset is folded in so the unit reports not-ready while held in reset.
  assign in_ready  = reset && (count_q < CNT_W'(DEPTH)) && !bus.flush;
  assign out_valid = (count_q != '0);
  assign push      = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready && !bus.flush;
  assign head      = mem_q[rd_ptr_q];

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_taken  = out_valid && head.flags.taken;
  assign bus.out_op_err = out_valid && head.flags.op_err;
  assign bus.out_tag    = out_valid ? head.tag : '0;
  assign bus.count      = count_q;

  // Next pointer/occupancy; flush overrides any push or pop this cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observable while counted valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{flags: new_flags, tag: bus.in_tag};
  end

endmodule

// File: tb/tb_branch_cmp.sv
// Self-checking bench for branch_cmp: vector table plus handshake corner sequences.
module tb_branch_cmp;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned TAG_W = 5;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        taken;
    logic        err;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [6:0] sb[$];
  logic [6:0] pending_exp;
  vec_t vecs[$];

  branch_cmp_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  branch_cmp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic taken, input logic err);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    pending_exp  = {taken, err, tag};
  endtask

  // Called with inputs settled mid-cycle: record accepts, score pops, advance one clock.
  task automatic step();
    logic [6:0] exp;
    if (bus.in_valid && bus.in_ready) sb.push_back(pending_exp);
    if (bus.out_valid && bus.out_ready && !bus.flush) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got tag 0x%0h expected no result", bus.out_tag);
      end else begin
        exp = sb.pop_front();
        chk("pop_result", {bus.out_taken, bus.out_op_err, bus.out_tag}, exp);
      end
    end
    if (bus.flush) sb.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0;
    bus.in_b = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
    pending_exp = '0;

    vecs.push_back('{4'd0,  32'h0000_1234, 32'h0000_1234, 1'b1, 1'b0});
    vecs.push_back('{4'd1,  32'd5,         32'd5,         1'b0, 1'b0});
    vecs.push_back('{4'd2,  32'h8000_0000, 32'd0,         1'b1, 1'b0});
    vecs.push_back('{4'd4,  32'h8000_0000, 32'd0,         1'b0, 1'b0});
    vecs.push_back('{4'd9,  32'd0,         32'd7,         1'b1, 1'b0});
    vecs.push_back('{4'd7,  32'd0,         32'd7,         1'b0, 1'b0});
    vecs.push_back('{4'd6,  32'hFFFF_FFFF, 32'd0,         1'b1, 1'b0});
    vecs.push_back('{4'd2,  32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0});
    vecs.push_back('{4'd3,  32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0});
    vecs.push_back('{4'd3,  32'd9,         32'd9,         1'b1, 1'b0});
    vecs.push_back('{4'd5,  32'hFFFF_FFFF, 32'd1,         1'b1, 1'b0});
    vecs.push_back('{4'd8,  32'h8000_0000, 32'd0,         1'b1, 1'b0});
    vecs.push_back('{4'd8,  32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0});
    vecs.push_back('{4'd7,  32'd1,         32'd5,         1'b1, 1'b0});
    vecs.push_back('{4'd6,  32'd1,         32'd0,         1'b0, 1'b0});
    vecs.push_back('{4'd0,  32'd1,         32'd2,         1'b0, 1'b0});
    vecs.push_back('{4'd12, 32'd3,         32'd3,         1'b0, 1'b1});
    vecs.push_back('{4'd15, 32'd0,         32'd0,         1'b0, 1'b1});

    // Reset values
    @(negedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_tag", {bus.out_taken, bus.out_op_err, bus.out_tag}, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    @(negedge clk);

    // Vector table, one request at a time, consumer always ready
    bus.out_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i), vecs[i].taken, vecs[i].err);
      #1;
      chk("no_passthrough", bus.out_valid, 0);
      step();
      bus.in_valid = 1'b0;
      #1;
      chk("latency_valid", bus.out_valid, 1);
      step();
    end

    // Backpressure with a full FIFO
    bus.out_ready = 1'b0;
    drive(4'd0, 32'd7, 32'd7, 5'd1, 1'b1, 1'b0);
    #1; chk("bp_ready_empty", bus.in_ready, 1); step();
    drive(4'd1, 32'd7, 32'd8, 5'd2, 1'b1, 1'b0);
    #1; step();
    drive(4'd4, 32'd1, 32'd2, 5'd3, 1'b1, 1'b0);
    #1;
    chk("bp_count_full", bus.count, 2);
    chk("bp_in_ready_full", bus.in_ready, 0);
    chk("bp_head_tag", bus.out_tag, 1);
    step();
    #1;
    chk("bp_head_stable", bus.out_tag, 1);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_full_pop_not_ready", bus.in_ready, 0);
    step();
    #1;
    chk("bp_count_after_pop", bus.count, 1);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("pushpop_count_kept", bus.count, 1);
    step();
    #1;
    chk("bp_drained", bus.count, 0);

    // Back-to-back stream wraps the pointers several times
    for (int i = 0; i < 8; i++) begin
      drive(4'd2, 32'(i), 32'd3, 5'(8 + i), (i < 3), 1'b0);
      #1;
      if (i > 0) chk("stream_count", bus.count, 1);
      step();
    end
    bus.in_valid = 1'b0;
    #1; step();
    #1;
    chk("stream_sb_empty", sb.size(), 0);
    chk("stream_count_end", bus.count, 0);

    // Flush with two queued results and a competing request
    bus.out_ready = 1'b0;
    drive(4'd0, 32'd0, 32'd0, 5'd20, 1'b1, 1'b0); #1; step();
    drive(4'd0, 32'd0, 32'd1, 5'd21, 1'b0, 1'b0); #1; step();
    drive(4'd0, 32'd4, 32'd4, 5'd22, 1'b1, 1'b0);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("flush_count_before", bus.count, 2);
    chk("flush_in_ready", bus.in_ready, 0);
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("flush_count", bus.count, 0);
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_out_zero", {bus.out_taken, bus.out_op_err, bus.out_tag}, 0);
    step();

    // Asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    drive(4'd9, 32'd1, 32'd0, 5'd30, 1'b1, 1'b0); #1; step();
    drive(4'd9, 32'd2, 32'd0, 5'd31, 1'b1, 1'b0); #1; step();
    bus.in_valid = 1'b0;
    #1;
    chk("mid_count_before", bus.count, 2);
    reset = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_release_ready", bus.in_ready, 1);
    chk("mid_release_empty", bus.out_valid, 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_cmp.md
# branch_cmp

Parametrised branch-condition unit for the decode stage of the pipelined MIPS core. It evaluates one of ten comparison modes (equality, signed/unsigned ordering, compare-with-zero) on two WIDTH-bit operands. It tags each result and queues it in a DEPTH-entry result FIFO. Producer and consumer use valid/ready handshakes, so branch resolution decouples from stall timing, and a pipeline flush discards pending results.

## Interface
- WIDTH, 32, operand width in bits (≥2)
- DEPTH, 2, result FIFO entries (power of 2, ≥2)
- TAG_W, 5, width of the tag carried with each request
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low (state clears while reset==0)
- flush  input  1  synchronous discard of all queued results
- in_valid  input  1  request present
- in_ready  output  1  unit can accept a request this cycle
- in_op  input  4  comparison mode (encoding below)
- in_a  input  WIDTH  operand A (rs)
- in_b  input  WIDTH  operand B (rt); ignored by zero-compare modes
- in_tag  input  TAG_W  opaque tag, returned with the result
- out_valid  output  1  head result present
- out_ready  input  1  consumer takes the head result
- out_taken  output  1  comparison result of the head entry
- out_op_err  output  1  head entry had an illegal in_op
- out_tag  output  TAG_W  tag of the head entry
- count  output  $clog2(DEPTH+1)  current occupancy

## Operation
- in_op encoding:
  - 0 EQ: a==b
  - 1 NE: a!=b
  - 2 LT: signed a<b
  - 3 GE: signed a>=b
  - 4 LTU: unsigned a<b
  - 5 GEU: unsigned a>=b
  - 6 LEZ: signed a<=0
  - 7 GTZ: signed a>0
  - 8 LTZ: signed a<0
  - 9 GEZ: signed a>=0
  - 10–15 illegal: stored with taken=0, op_err=1
- Signed modes treat bit WIDTH-1 as the sign, two's complement, with no overflow. The compare must not use subtraction-overflow tricks.
- Accept: in_valid && in_ready.
  - The result {taken, op_err, tag} is computed from the request inputs in the same cycle and written at the FIFO tail.
- in_ready = (count<DEPTH) && !flush. It has no combinational dependence on out_ready, so a full FIFO stays not-ready even when it is popping.
- Pop: out_valid && out_ready. The head pointer advances.
- out_valid = (count!=0). When empty, out_taken, out_op_err and out_tag are driven to 0.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- flush: at the next edge, count=0 and both pointers=0. Any pop in that cycle is void (out_ready is ignored).
- Outputs are stable while out_valid && !out_ready. In-order delivery is guaranteed.

## Timing
- Latency: a request accepted at edge N is visible at the outputs after edge N (out_valid=1 in cycle N+1) when the FIFO was empty. There is no pass-through within the same cycle.
- Throughput: 1 result per cycle while out_ready is held high.
- Reset (reset==0): count=0, pointers=0, out_valid=0, out_taken=0, out_op_err=0, out_tag=0, in_ready=0. in_ready=1 in the first cycle after reset deasserts (if flush==0).
- Reset mid-operation: queued entries are lost immediately (asynchronous). No partial pop or push survives.
- flush wins over a simultaneous accept, because in_ready is forced to 0.

## Structure
- Package branch_cmp_pkg holds:
  - the op encoding as localparams or an enum: OP_EQ..OP_GEZ, OP_W=4
  - a result struct/width constant for {taken, op_err, tag}
- Sub-module cmp_eval: purely combinational, parameter WIDTH, ports op, a, b → taken, op_err.
- The top level holds the FIFO storage, pointers, count and handshake logic.

## Test plan
- Reset then single requests, WIDTH=32, out_ready=1:
  - EQ a=b=0x1234 → taken=1
  - NE a=5,b=5 → taken=0
  - each result appears exactly one cycle after accept
- Sign boundaries:
  - LT a=0x80000000,b=0 → taken=1
  - LTU same operands → taken=0
  - GEZ a=0 → taken=1
  - GTZ a=0 → taken=0
  - LEZ a=0xFFFFFFFF → taken=1
- Backpressure, DEPTH=2, out_ready=0:
  - three requests with tags 1,2,3 → first two accepted, count=2, in_ready=0, tag 3 held by producer
  - then out_ready=1 → tags emerge 1,2,3 in order
- Simultaneous push/pop with count=1 → count stays 1. Pointer wrap is exercised over 8 consecutive requests with the correct tag order.
- Flush and illegal op:
  - flush with count=2 while in_valid=1 → next cycle count=0, out_valid=0, request not accepted
  - in_op=12 → taken=0, op_err=1
- Assert reset=0 with count=2 mid-stream → out_valid=0 immediately and count=0. After release, in_ready=1.
